seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an 8-digit 7-segment display.
//  Drives the 3-bit select of the 8:1 7-bit segment mux that sits directly downstream.
//  Drives the per-digit common enables and inserts a blanking gap between digits to
//  suppress ghosting. Emits a one-cycle frame tick per full scan.
// PARAMETERS
//  DIV_WIDTH   16  width of the slot-length divider input
//  BLANK_CYC   4   cycles per slot with all digits off, at slot start; legal range 1..255
//  ACTIVE_LOW  1   1: digit_en active-low (inactive = 8'hFF); 0: active-high (inactive = 8'h00)
// PORTS
//  clk         in   1          system clock
//  rst         in   1          synchronous reset, active-high
//  enable      in   1          1 = scanning, 0 = display dark
//  div_value   in   DIV_WIDTH  slot length minus 1, in clk cycles
//  sel         out  3          digit index to downstream segment mux
//  digit_en    out  8          one-hot digit common enables, polarity set by ACTIVE_LOW
//  seg_blank   out  1          1 = digits are off; downstream gates the segments with it
//  frame_tick  out  1          one-cycle pulse when sel wraps 7 -> 0
// BEHAVIOUR
//  - All outputs are registered and change only on posedge clk.
//  - Reset state: sel=0, digit_en=inactive, seg_blank=1, frame_tick=0, FSM=IDLE, counters=0.
//  - rst has priority over every other input.
//  - FSM states: IDLE, BLANK, SHOW.
//  - IDLE
//    - While enable=0: outputs hold reset values.
//    - When enable=1: go to BLANK next cycle, slot counter=0.
//  - Slot length
//    - L = max(div_value+1, BLANK_CYC+1).
//    - div_value is sampled at the first BLANK cycle of each slot and held for the whole slot.
//  - BLANK
//    - Lasts BLANK_CYC cycles.
//    - digit_en=inactive, seg_blank=1.
//    - Then go to SHOW.
//  - SHOW
//    - Lasts L-BLANK_CYC cycles (minimum 1).
//    - digit_en[sel] active, all other bits inactive, seg_blank=0.
//  - End of slot (last SHOW cycle)
//    - sel increments modulo 8, and FSM returns to BLANK.
//    - sel changes only while entering BLANK, so the mux select never moves while a digit is lit.
//    - On the 7 -> 0 wrap, frame_tick=1 for exactly the first BLANK cycle of digit 0.
//  - enable falls mid-slot (any state): next cycle FSM=IDLE, outputs return to reset values.
//    Re-enabling starts a fresh slot on digit 0.
//  - div_value changes mid-slot: no effect until the next slot.
//  - Counter width is DIV_WIDTH. The counter must not overflow when div_value is all-ones.
//  - digit_en is never active on two digits in the same cycle.
// CONFIGURATION
//  - Macro: SEG7_SCAN_DIMMING_EN
//  - When defined
//    - Adds input port brightness[3:0].
//    - A free-running 4-bit counter d, cleared to 0 at the start of each SHOW phase,
//      increments every SHOW cycle.
//    - digit_en[sel] is active and seg_blank=0 only while d < brightness.
//      Otherwise digit_en=inactive and seg_blank=1.
//    - brightness=0: display fully dark, while sel and frame_tick still advance normally.
//  - When not defined: no brightness port; the full SHOW phase is lit.
// TESTING
//  - Reset: hold rst=1 for 3 cycles with enable=1 -> sel=0, digit_en=8'hFF, seg_blank=1, frame_tick=0.
//  - Normal scan (div_value=9, BLANK_CYC=4) -> each slot is 10 cycles: 4 blank, 6 lit.
//    sel runs 0..7. frame_tick pulses every 80 cycles.
//  - Clamp (div_value=0, BLANK_CYC=4) -> slot is 5 cycles: 4 blank, 1 lit. Never zero lit cycles.
//  - Drop enable in SHOW of digit 5 -> next cycle sel=0, digit_en=8'hFF. Re-enable -> BLANK on digit 0.
//  - Change div_value from 9 to 19 mid-slot -> current slot stays 10 cycles, next slot is 20.
//    Checker also confirms that no two digit_en bits are ever active together.
//  - SEG7_SCAN_DIMMING_EN, div_value=19, brightness=4 -> exactly 4 lit cycles per slot.
//    brightness=0 -> zero lit cycles, and frame_tick still pulses every 160 cycles.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller for an 8-digit 7-segment display.
// Each digit gets one slot. A slot opens with BLANK_CYC cycles where all digit
// commons are off, which suppresses ghosting while the downstream segment mux
// settles. The rest of the slot lights the selected digit. The digit select
// advances only when a new blanking gap begins. A one-cycle frame tick marks
// the start of digit 0 after the 7 -> 0 wrap.
//
// Optional feature macro: SEG7_SCAN_DIMMING_EN
//   When defined, a brightness[3:0] input is added. A 4-bit counter restarts
//   at each SHOW phase, and the digit is lit only while the counter is below
//   brightness.
//
// Parameters
//   DIV_WIDTH   width of div_value and of the slot counter
//   BLANK_CYC   blank cycles at the start of every slot (1..255)
//   ACTIVE_LOW  1: digit_en active-low, 0: active-high
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   enable      1 = scanning, 0 = display dark (back to idle)
//   div_value   slot length minus 1, in clk cycles
//   brightness  (SEG7_SCAN_DIMMING_EN only) lit cycles per 16 SHOW cycles
//   sel         digit index to the downstream segment mux
//   digit_en    one-hot digit common enables, polarity set by ACTIVE_LOW
//   seg_blank   1 = digits are off; downstream gates the segments with it
//   frame_tick  one-cycle pulse on the first cycle of digit 0 after a wrap
// ============================================================================
module seg7_scan_ctrl #(
    parameter int DIV_WIDTH  = 16,
    parameter int BLANK_CYC  = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
`ifdef SEG7_SCAN_DIMMING_EN
    input  logic [3:0]           brightness,
`endif
    output logic [2:0]           sel,
    output logic [7:0]           digit_en,
    output logic                 seg_blank,
    output logic                 frame_tick
);

    localparam logic [7:0]           EN_OFF     = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] BLANK_CNT  = DIV_WIDTH'(BLANK_CYC);
    localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [DIV_WIDTH-1:0] cnt, cnt_nx;
    // Index of the last cycle of the current slot, i.e. L-1. Clamping it to
    // at least BLANK_CYC guarantees one lit cycle and keeps the counter from
    // ever passing the largest value div_value can hold.
    logic [DIV_WIDTH-1:0] lim, lim_nx;
    logic [2:0]           sel_nx;
    logic [7:0]           en_nx;
    logic                 blank_nx;
    logic                 tick_nx;
    logic                 lit_nx;
`ifdef SEG7_SCAN_DIMMING_EN
    logic [3:0]           dim, dim_nx;
`endif

    // Next-state and next-output logic. Outputs are computed from the next
    // state so that, once registered, they line up with the state they describe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        lim_nx   = lim;
        sel_nx   = sel;
        tick_nx  = 1'b0;

        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            sel_nx   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    sel_nx   = 3'd0;
                end
                BLANK: begin
                    // The slot length is frozen on the first blank cycle, so
                    // div_value changes mid-slot only affect the next slot.
                    if (cnt == '0) begin
                        lim_nx = (div_value > BLANK_CNT) ? div_value : BLANK_CNT;
                    end
                    cnt_nx = cnt + CNT_ONE;
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == lim) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        sel_nx   = sel + 3'd1;
                        tick_nx  = (sel == 3'd7);
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    sel_nx   = 3'd0;
                end
            endcase
        end

`ifdef SEG7_SCAN_DIMMING_EN
        // The dimming counter is 0 on the first SHOW cycle and counts up
        // (wrapping at 16) for as long as SHOW lasts.
        dim_nx = (state == SHOW) ? dim + 4'd1 : 4'd0;
        lit_nx = (state_nx == SHOW) && (dim_nx < brightness);
`else
        lit_nx = (state_nx == SHOW);
`endif

        if (lit_nx) begin
            en_nx = ACTIVE_LOW ? ~(8'd1 << sel_nx) : (8'd1 << sel_nx);
        end else begin
            en_nx = EN_OFF;
        end
        blank_nx = !lit_nx;
    end

    // State and output registers. Reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lim        <= '0;
            sel        <= 3'd0;
            digit_en   <= EN_OFF;
            seg_blank  <= 1'b1;
            frame_tick <= 1'b0;
`ifdef SEG7_SCAN_DIMMING_EN
            dim        <= 4'd0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            lim        <= lim_nx;
            sel        <= sel_nx;
            digit_en   <= en_nx;
            seg_blank  <= blank_nx;
            frame_tick <= tick_nx;
`ifdef SEG7_SCAN_DIMMING_EN
            dim        <= dim_nx;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for seg7_scan_ctrl. The expected display is derived
// from the slot rule: each slot is max(div_value+1, BLANK_CYC+1) cycles long,
// the first BLANK_CYC are dark, and the rest light digit 'sel'. With
// SEG7_SCAN_DIMMING_EN defined, only the first 'brightness' cycles of every
// 16 lit cycles stay lit.
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int DW      = 16;
    localparam int BC      = 4;
    localparam bit ACT_LOW = 1'b1;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] en;
        logic       blank;
        logic       tick;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] div_value;
    logic [3:0]    brightness;
    logic [2:0]    sel;
    logic [7:0]    digit_en;
    logic          seg_blank;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    // Scan position as seen by the bench: digit of the next slot and whether
    // that slot directly follows a digit-7 slot.
    int cur_digit = 0;
    bit wrapped   = 1'b0;
    // Brightness used by the expected-value function; -1 means no dimming.
    int bright_m  = -1;

    seg7_scan_ctrl #(
        .DIV_WIDTH (DW),
        .BLANK_CYC (BC),
        .ACTIVE_LOW(ACT_LOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .div_value (div_value),
`ifdef SEG7_SCAN_DIMMING_EN
        .brightness(brightness),
`endif
        .sel       (sel),
        .digit_en  (digit_en),
        .seg_blank (seg_blank),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Slot length in cycles for a given div_value.
    function automatic int slot_len(input int dv);
        return (dv + 1 > BC + 1) ? dv + 1 : BC + 1;
    endfunction

    // Expected outputs at position p (0-based) of the slot for digit d.
    function automatic exp_t expect_at(input int d, input int p, input int br, input bit wrap);
        exp_t e;
        bit   lit;
        logic [7:0] onehot;
        lit = (p >= BC) && ((br < 0) || (((p - BC) % 16) < br));
        onehot  = 8'd1 << d;
        e.sel   = 3'(d);
        e.en    = lit ? (ACT_LOW ? ~onehot : onehot) : (ACT_LOW ? 8'hFF : 8'h00);
        e.blank = !lit;
        e.tick  = wrap && (p == 0) && (d == 0);
        return e;
    endfunction

    // Leaves the design in its first BLANK cycle on digit 0. Must be entered
    // while the design is idle.
    task automatic start_scan();
        enable = 1'b1;
        @(posedge clk); #1;
        cur_digit = 0;
        wrapped   = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        e = '{sel: 3'd0, en: (ACT_LOW ? 8'hFF : 8'h00), blank: 1'b1, tick: 1'b0};
        rst       = 1'b1;
        enable    = 1'b1;
        div_value = 16'd9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sel, digit_en, seg_blank, frame_tick} !== e) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got sel=%0d en=%h blank=%b tick=%b, expected sel=0 en=%h blank=1 tick=0",
                         i, sel, digit_en, seg_blank, frame_tick, e.en);
            end
        end
        rst    = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({sel, digit_en, seg_blank, frame_tick} !== e) begin
                errors++;
                $display("[TB] FAIL idle cycle %0d: got sel=%0d en=%h blank=%b tick=%b, expected sel=0 en=%h blank=1 tick=0",
                         i, sel, digit_en, seg_blank, frame_tick, e.en);
            end
        end
    endtask

    // Runs nslots complete slots with div_value drawn from [dlo, dhi],
    // checking every cycle against the slot rule.
    task automatic test_scan(input string name, input int nslots, input int dlo, input int dhi);
        exp_t e;
        int   dv;
        int   len;
        for (int s = 0; s < nslots; s++) begin
            dv        = int'($urandom_range(dhi, dlo));
            div_value = DW'(dv);
            len       = slot_len(dv);
            for (int p = 0; p < len; p++) begin
                e = expect_at(cur_digit, p, bright_m, wrapped);
                checks++;
                if ({sel, digit_en, seg_blank, frame_tick} !== e) begin
                    errors++;
                    $display("[TB] FAIL %s slot %0d pos %0d: got sel=%0d en=%h blank=%b tick=%b, expected sel=%0d en=%h blank=%b tick=%b",
                             name, s, p, sel, digit_en, seg_blank, frame_tick, e.sel, e.en, e.blank, e.tick);
                end
                checks++;
                if ($countones(ACT_LOW ? ~digit_en : digit_en) > 1) begin
                    errors++;
                    $display("[TB] FAIL %s onehot slot %0d pos %0d: got en=%h, expected at most one active bit",
                             name, s, p, digit_en);
                end
                @(posedge clk); #1;
            end
            wrapped   = (cur_digit == 7);
            cur_digit = (cur_digit + 1) % 8;
        end
    endtask

    // div_value moves from 9 to 19 after the slot has started: that slot keeps
    // 10 cycles and the following one becomes 20.
    task automatic test_div_change();
        exp_t e;
        int   dv_slot;
        for (int s = 0; s < 2; s++) begin
            dv_slot = (s == 0) ? 9 : 19;
            for (int p = 0; p < slot_len(dv_slot); p++) begin
                if (s == 0 && p == 0) div_value = 16'd9;
                if (s == 0 && p == 3) div_value = 16'd19;
                e = expect_at(cur_digit, p, bright_m, wrapped);
                checks++;
                if ({sel, digit_en, seg_blank, frame_tick} !== e) begin
                    errors++;
                    $display("[TB] FAIL div_change slot %0d pos %0d: got sel=%0d en=%h blank=%b tick=%b, expected sel=%0d en=%h blank=%b tick=%b",
                             s, p, sel, digit_en, seg_blank, frame_tick, e.sel, e.en, e.blank, e.tick);
                end
                @(posedge clk); #1;
            end
            wrapped   = (cur_digit == 7);
            cur_digit = (cur_digit + 1) % 8;
        end
    endtask

    // Drop enable while digit 5 is lit, then re-enable and expect a fresh
    // scan beginning at digit 0.
    task automatic test_enable_drop();
        exp_t e;
        test_scan("to_digit5", (13 - cur_digit) % 8, 9, 9);
        div_value = 16'd9;
        repeat (6) begin
            @(posedge clk); #1;
        end
        e = expect_at(5, 6, bright_m, 1'b0);
        checks++;
        if ({sel, digit_en, seg_blank} !== {e.sel, e.en, e.blank}) begin
            errors++;
            $display("[TB] FAIL drop_show: got sel=%0d en=%h blank=%b, expected sel=%0d en=%h blank=%b",
                     sel, digit_en, seg_blank, e.sel, e.en, e.blank);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sel, digit_en, seg_blank, frame_tick} !== {3'd0, (ACT_LOW ? 8'hFF : 8'h00), 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL drop_idle: got sel=%0d en=%h blank=%b tick=%b, expected sel=0 en=%h blank=1 tick=0",
                     sel, digit_en, seg_blank, frame_tick, (ACT_LOW ? 8'hFF : 8'h00));
        end
        start_scan();
        test_scan("reenable", 9, 0, 12);
    endtask

`ifdef SEG7_SCAN_DIMMING_EN
    task automatic test_dimming();
        enable = 1'b0;
        @(posedge clk); #1;
        brightness = 4'd4;
        bright_m   = 4;
        start_scan();
        test_scan("dim4", 8, 19, 19);
        test_scan("dim4_long", 3, 40, 50);
        enable = 1'b0;
        @(posedge clk); #1;
        brightness = 4'd0;
        bright_m   = 0;
        start_scan();
        test_scan("dim0", 17, 19, 19);
    endtask
`endif

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        div_value  = '0;
        brightness = 4'd15;
`ifdef SEG7_SCAN_DIMMING_EN
        bright_m   = 15;
`endif
        test_reset();
        start_scan();
        test_scan("normal", 17, 9, 9);
        test_scan("clamp", 9, 0, 0);
        test_scan("random", 12, 0, 40);
        test_div_change();
        test_enable_drop();
`ifdef SEG7_SCAN_DIMMING_EN
        test_dimming();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
